// File: rtl/kogge_pkg.sv
// Shared definitions for the multi-precision kogge sequencer: the state encoding and
// the word-slice offset helper.
package kogge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    // Bit offset of word idx within a packed multi-word operand.
    function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/kogge.sv
// Combinational W-bit Kogge-Stone adder with carry-in and carry-out.
module kogge #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    localparam int unsigned L = $clog2(W);

    logic [W-1:0] g [L+1];
    logic [W-1:0] p [L+1];
    logic [W:0]   c;
    logic [W-1:0] low_mask;

    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        low_mask = '0;
        for (int l = 1; l <= int'(L); l++) begin
            // Bits below the span keep their group propagate unchanged.
            low_mask = ~({W{1'b1}} << (1 << (l - 1)));
            g[l] = g[l-1] | (p[l-1] & (g[l-1] << (1 << (l - 1))));
            p[l] = p[l-1] & ((p[l-1] << (1 << (l - 1))) | low_mask);
        end
        c[0] = cin;
        c[W:1] = g[L] | (p[L] & {W{cin}});
        s = p[0] ^ c[W-1:0];
        cout = c[W];
    end

endmodule

// File: rtl/kogge_mp_seq.sv
// Multi-precision add/subtract sequencer: streams NWORDS word slices LSW-first through
// one shared kogge adder, chaining the carry through a register.
module kogge_mp_seq
    import kogge_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned NWORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W*NWORDS-1:0] op_a,
    input  logic [W*NWORDS-1:0] op_b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W*NWORDS-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int unsigned N  = W * NWORDS;
    localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NWORDS - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  add_a, add_b, add_s;
    logic          add_cout;
    int unsigned   lsb;

    assign lsb   = word_lsb(int'(idx_q), W);
    assign add_a = a_q[lsb +: W];
    assign add_b = b_q[lsb +: W];

    kogge #(
        .W(W)
    ) u_kogge (
        .a   (add_a),
        .b   (add_b),
        .cin (carry_q),
        .s   (add_s),
        .cout(add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction is folded into A + ~B + 1 at accept time.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[lsb +: W] = add_s;
                carry_d = add_cout;
                if (idx_q == LastIdx) begin
                    cout_d  = add_cout;
                    ovf_d   = (a_q[N-1] == b_q[N-1]) & (add_s[W-1] != a_q[N-1]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
